key_matrix_emu: RTL and testbench

- Emulates the Atari 8-bit keyboard matrix directly upstream of the POKEY keyboard scan core.
- Accepts host key make/break events through a small FIFO and holds the resulting key state in a 64-entry bitmap plus shift, control and break flags.
- Answers the core's scan address K with the KR1/KR2 return lines.
- Paces event application in whole scan cycles, so the core's two-scan debounce always sees a stable key.

---
 rtl/key_pkg.sv | 17 +
 rtl/key_evt_fifo.sv | 41 ++++
 rtl/key_matrix_emu.sv | 96 +++++++++
 tb/tb_key_matrix_emu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared event kinds, scan-address decode values and event record for the key matrix emulator
package key_pkg;
   localparam logic [1:0] KIND_NORMAL  = 2'd0;
   localparam logic [1:0] KIND_SHIFT   = 2'd1;
   localparam logic [1:0] KIND_CONTROL = 2'd2;
   localparam logic [1:0] KIND_BREAK   = 2'd3;
   localparam logic [5:0] K_CONTROL = 6'h3F;
   localparam logic [5:0] K_SHIFT   = 6'h2F;
   localparam logic [5:0] K_BREAK   = 6'h0F;
   localparam int EV_W = 9;
   typedef enum logic [1:0] {IDLE, APPLY, HOLD} keyState_t;
   typedef struct packed {
      logic       make;
      logic [1:0] kind;
      logic [5:0] code;
   } keyEvent_t;
endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: small synchronous event FIFO with full/empty flags and a flush input
module key_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wrData,
   output logic [W-1:0] rdData,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [CW-1:0] count;
   logic          doPush, doPop;
   assign full   = count == CW'(DEPTH);
   assign empty  = count == '0;
   assign doPush = push & ~full & ~flush;
   assign doPop  = pop & ~empty;
   assign rdData = mem[rdPtr];
   // storage is written only on accepted pushes; contents need no reset
   always_ff @(posedge clk)
      if (doPush) mem[wrPtr] <= wrData;
   // pointers wrap naturally at DEPTH (power of two); flush empties the queue
   always_ff @(posedge clk or posedge rst)
      if (rst || flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop) rdPtr <= rdPtr + AW'(1);
         count <= count + CW'(doPush) - CW'(doPop);
      end
endmodule

// File: rtl/key_matrix_emu.sv
// key_matrix_emu: Atari 8-bit keyboard matrix emulation feeding the POKEY scan core (KEY_MATRIX_CLEAR_EN adds clear_all)
module key_matrix_emu #(
   parameter int FIFO_DEPTH = 4,
   parameter int HOLD_SCANS = 2
) (
   input  logic       clk,
   input  logic       rst,
`ifdef KEY_MATRIX_CLEAR_EN
   input  logic       clear_all,
`endif
   input  logic [5:0] K,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [5:0] ev_code,
   input  logic [1:0] ev_kind,
   input  logic       ev_make,
   output logic [1:0] KR,
   output logic       busy
);
   import key_pkg::*;
   localparam int SW = $clog2(HOLD_SCANS + 2);
   keyState_t       state, nextState;
   keyEvent_t       head;
   logic [EV_W-1:0] headRaw;
   logic [63:0]     bitmap;
   logic            shiftF, ctrlF, breakF;
   logic [SW-1:0]   scanCnt;
   logic [5:0]      kQ, keyIdx;
   logic            wrap, pop, full, empty, clr;
`ifdef KEY_MATRIX_CLEAR_EN
   assign clr = clear_all;
`else
   assign clr = 1'b0;
`endif
   assign head     = headRaw;
   assign keyIdx   = ~K;
   assign wrap     = (K == K_CONTROL) & (kQ != K_CONTROL);
   assign ev_ready = ~full;
   assign busy     = ~empty | (state != IDLE);
   key_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(EV_W)) uFifo (
      .clk    (clk),
      .rst    (rst),
      .flush  (clr),
      .push   (ev_valid),
      .pop    (pop),
      .wrData ({ev_make, ev_kind, ev_code}),
      .rdData (headRaw),
      .full   (full),
      .empty  (empty)
   );
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nextState;
   // next state and pop: one event per APPLY, then wait HOLD_SCANS scan starts
   always_comb begin
      nextState = state;
      pop       = 1'b0;
      case (state)
         IDLE:  if (!empty) nextState = APPLY;
         APPLY: begin
            pop       = 1'b1;
            nextState = HOLD_SCANS > 0 ? HOLD : IDLE;
         end
         HOLD:  if (wrap && scanCnt == SW'(1)) nextState = IDLE;
         default: nextState = IDLE;
      endcase
      if (clr) nextState = IDLE;
   end
   // key state, pacing counter, K history and registered return lines
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bitmap  <= '0;
         shiftF  <= 1'b0;
         ctrlF   <= 1'b0;
         breakF  <= 1'b0;
         scanCnt <= '0;
         kQ      <= 6'h3F;
         KR      <= 2'b11;
      end else begin
         kQ <= K;
         KR <= {K == K_CONTROL ? ~ctrlF : K == K_SHIFT ? ~shiftF : K == K_BREAK ? ~breakF : 1'b1, ~bitmap[keyIdx]};
         if (clr) begin
            bitmap <= '0;
            shiftF <= 1'b0;
            ctrlF  <= 1'b0;
            breakF <= 1'b0;
         end else if (state == APPLY) begin
            scanCnt <= SW'(HOLD_SCANS);
            if (head.kind == KIND_NORMAL) bitmap[head.code] <= head.make;
            if (head.kind == KIND_SHIFT) shiftF <= head.make;
            if (head.kind == KIND_CONTROL) ctrlF <= head.make;
            if (head.kind == KIND_BREAK) breakF <= head.make;
         end else if (state == HOLD && wrap) scanCnt <= scanCnt - SW'(1);
      end
endmodule

// File: tb/tb_key_matrix_emu.sv
// tb_key_matrix_emu: directed self-checking bench for key_matrix_emu (KR bit 0 = KR1, bit 1 = KR2)
module tb_key_matrix_emu;
   import key_pkg::*;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] K = 6'h3F;
   logic       ev_valid = 1'b0;
   logic [5:0] ev_code = '0;
   logic [1:0] ev_kind = '0;
   logic       ev_make = 1'b0;
   logic       ev_ready, busy;
   logic [1:0] KR;
`ifdef KEY_MATRIX_CLEAR_EN
   logic       clear_all = 1'b0;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_matrix_emu #(.FIFO_DEPTH(4), .HOLD_SCANS(2)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef KEY_MATRIX_CLEAR_EN
      .clear_all(clear_all),
`endif
      .K        (K),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_code  (ev_code),
      .ev_kind  (ev_kind),
      .ev_make  (ev_make),
      .KR       (KR),
      .busy     (busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] kind, input logic [5:0] code, input logic make);
      ev_valid = 1'b1;
      ev_kind  = kind;
      ev_code  = code;
      ev_make  = make;
      tick();
      ev_valid = 1'b0;
   endtask

   task automatic doWrap;
      K = 6'h00;
      tick();
      K = 6'h3F;
      tick();
   endtask

   task automatic drain;
      int n = 0;
      while (busy && n < 40) begin
         doWrap();
         n++;
      end
      chk("drain_busy", {1'b0, busy}, 2'b00);
   endtask

   task automatic probe(input string tag, input logic [5:0] k, input logic [1:0] exp);
      K = k;
      tick();
      chk(tag, KR, exp);
   endtask

   initial begin
      #2 rst = 1'b1;
      for (int k = 63; k >= 0; k--) begin
         probe("rst_kr", 6'(k), 2'b11);
         chk("rst_ready", {1'b0, ev_ready}, 2'b01);
         chk("rst_busy", {1'b0, busy}, 2'b00);
      end
      rst = 1'b0;
      K = 6'h00;
      tick();
      // normal key 0x21 (K = 0x1E) make then a queued release
      push(KIND_NORMAL, 6'h21, 1'b1);
      push(KIND_NORMAL, 6'h21, 1'b0);
      tick();
      probe("key21_pressed", 6'h1E, 2'b10);
      probe("key21_other", 6'h1F, 2'b11);
      chk("key21_busy", {1'b0, busy}, 2'b01);
      doWrap();
      probe("key21_wrap1", 6'h1E, 2'b10);
      doWrap();
      probe("key21_wrap2", 6'h1E, 2'b10);
      tick();
      probe("key21_released", 6'h1E, 2'b11);
      drain();
      // modifiers
      push(KIND_SHIFT, 6'h00, 1'b1);
      push(KIND_CONTROL, 6'h00, 1'b1);
      drain();
      probe("shift_on", 6'h2F, 2'b01);
      probe("ctrl_on", 6'h3F, 2'b01);
      probe("break_off", 6'h0F, 2'b11);
      push(KIND_BREAK, 6'h00, 1'b1);
      drain();
      probe("break_on", 6'h0F, 2'b01);
      // fill the FIFO with K held still (no wraps)
      K = 6'h05;
      ev_valid = 1'b1;
      ev_kind = KIND_NORMAL;
      ev_make = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         ev_code = 6'(i);
         tick();
      end
      ev_valid = 1'b0;
      chk("full_ready", {1'b0, ev_ready}, 2'b00);
      chk("full_busy", {1'b0, busy}, 2'b01);
      drain();
      probe("full_key1", ~6'd1, 2'b10);
      probe("full_key5", ~6'd5, 2'b10);
      probe("full_key6_dropped", ~6'd6, 2'b11);
      // reset during HOLD with three events queued
      K = 6'h05;
      ev_valid = 1'b1;
      for (int i = 10; i <= 13; i++) begin
         ev_code = 6'(i);
         tick();
      end
      ev_valid = 1'b0;
      probe("hold_key10", ~6'd10, 2'b10);
      chk("hold_busy", {1'b0, busy}, 2'b01);
      rst = 1'b1;
      #1;
      chk("midrst_kr", KR, 2'b11);
      chk("midrst_ready", {1'b0, ev_ready}, 2'b01);
      chk("midrst_busy", {1'b0, busy}, 2'b00);
      tick();
      rst = 1'b0;
      probe("midrst_key10", ~6'd10, 2'b11);
      probe("midrst_key5", ~6'd5, 2'b11);
      probe("midrst_break", 6'h0F, 2'b11);
      doWrap();
      doWrap();
      chk("midrst_idle", {1'b0, busy}, 2'b00);
      probe("midrst_key11", ~6'd11, 2'b11);
`ifdef KEY_MATRIX_CLEAR_EN
      for (int i = 20; i <= 24; i++) push(KIND_NORMAL, 6'(i), 1'b1);
      drain();
      probe("clr_key20_before", ~6'd20, 2'b10);
      clear_all = 1'b1;
      ev_valid = 1'b1;
      ev_kind = KIND_NORMAL;
      ev_code = 6'd30;
      ev_make = 1'b1;
      tick();
      clear_all = 1'b0;
      ev_valid = 1'b0;
      chk("clr_busy", {1'b0, busy}, 2'b00);
      probe("clr_key20", ~6'd20, 2'b11);
      probe("clr_key24", ~6'd24, 2'b11);
      probe("clr_key30_dropped", ~6'd30, 2'b11);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
